multimode_ff_reg: RTL and testbench

MULTIMODE_FF_REG -- requirements
Module: multimode_ff_reg

---
 rtl/multimode_ff_reg.sv | 79 +++++++
 tb/tb_multimode_ff_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_ff_reg.sv
// Multi-mode register: per-bit D / T / JK / SR next-state with
// previous-value tracking, sticky SR-illegal flag and a change counter.
module multimode_ff_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_prev,
  output logic [WIDTH-1:0] changed,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_SR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_prev_q, q_prev_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_nxt;
  logic             err_set;

  always_comb begin
    q_nxt = q_q;
    unique case (mode)
      M_D:  q_nxt = a;
      M_T:  q_nxt = q_q ^ a;
      M_JK: q_nxt = (a & ~q_q) | (~b & q_q);
      // illegal S=R=1 keeps the bit; flagged via err
      M_SR: q_nxt = (a & ~b) | (q_q & ~(b & ~a));
      default: q_nxt = q_q;
    endcase
  end

  always_comb begin
    q_d      = en ? q_nxt : q_q;
    q_prev_d = q_q;
    err_set  = en && (mode == M_SR) && ((a & b) != '0);
    err_d    = err_q;
    if (err_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    cnt_d    = cnt_q;
    if ((q_d != q_q) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
    if (reset_sync) begin
      q_d      = RST_VAL;
      q_prev_d = RST_VAL;
      err_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    q_q      <= q_d;
    q_prev_q <= q_prev_d;
    err_q    <= err_d;
    cnt_q    <= cnt_d;
  end

  assign Q       = q_q;
  assign Q_prev  = q_prev_q;
  assign changed = q_q ^ q_prev_q;
  assign err     = err_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_multimode_ff_reg.sv
// Directed bench for multimode_ff_reg: default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation.
module tb_multimode_ff_reg;

  logic       clk = 1'b0;
  logic       reset_sync;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a, b;
  logic       clr_err;

  logic [3:0] q, q_prev, changed;
  logic       err;
  logic [7:0] cnt;

  logic [3:0] q2, q_prev2, changed2;
  logic       err2;
  logic [1:0] cnt2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multimode_ff_reg dut (
    .clk(clk), .reset_sync(reset_sync), .en(en), .mode(mode),
    .a(a), .b(b), .clr_err(clr_err),
    .Q(q), .Q_prev(q_prev), .changed(changed),
    .err(err), .chg_cnt(cnt)
  );

  multimode_ff_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_sync(reset_sync), .en(en), .mode(mode),
    .a(a), .b(b), .clr_err(clr_err),
    .Q(q2), .Q_prev(q_prev2), .changed(changed2),
    .err(err2), .chg_cnt(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_sync = 1; en = 1; mode = 2'b00; a = 4'hF; b = 4'h0;
    clr_err = 0;
    step(); step();
    checks++;
    if (q !== 4'h0) begin
      fails++; $display("FAIL reset_q got %h exp 0", q);
    end
    checks++;
    if (q_prev !== 4'h0) begin
      fails++; $display("FAIL reset_qprev got %h exp 0", q_prev);
    end
    checks++;
    if (changed !== 4'h0) begin
      fails++; $display("FAIL reset_changed got %h exp 0", changed);
    end
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL reset_err got %b exp 0", err);
    end
    checks++;
    if (cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt got %0d exp 0", cnt);
    end
    reset_sync = 0;
  endtask

  task automatic test_d_mode();
    en = 1; mode = 2'b00; a = 4'hA;
    step();
    checks++;
    if (q !== 4'hA || changed !== 4'hA || cnt !== 8'd1) begin
      fails++;
      $display("FAIL d_load q=%h chg=%h cnt=%0d exp A A 1",
               q, changed, cnt);
    end
    step();
    checks++;
    if (q !== 4'hA || changed !== 4'h0 || cnt !== 8'd1) begin
      fails++;
      $display("FAIL d_same q=%h chg=%h cnt=%0d exp A 0 1",
               q, changed, cnt);
    end
    en = 0; a = 4'h5;
    step();
    checks++;
    if (q !== 4'hA || cnt !== 8'd1) begin
      fails++;
      $display("FAIL d_hold q=%h cnt=%0d exp A 1", q, cnt);
    end
  endtask

  task automatic test_t_mode();
    en = 1; mode = 2'b01; a = 4'h3; b = 4'hF;
    step();
    checks++;
    if (q !== 4'h9 || changed !== 4'h3 || q_prev !== 4'hA) begin
      fails++;
      $display("FAIL t_first q=%h chg=%h prev=%h exp 9 3 A",
               q, changed, q_prev);
    end
    step();
    checks++;
    if (q !== 4'hA || cnt !== 8'd3) begin
      fails++;
      $display("FAIL t_second q=%h cnt=%0d exp A 3", q, cnt);
    end
  endtask

  task automatic test_en_hold();
    en = 0; a = 4'h5; b = 4'h0;
    for (int m = 0; m < 4; m++) begin
      mode = m[1:0];
      step();
    end
    checks++;
    if (q !== 4'hA || cnt !== 8'd3 || err !== 1'b0) begin
      fails++;
      $display("FAIL en_hold q=%h cnt=%0d err=%b exp A 3 0",
               q, cnt, err);
    end
  endtask

  task automatic test_jk_mode();
    reset_sync = 1; step(); reset_sync = 0;
    en = 1; mode = 2'b10; a = 4'b1100; b = 4'b1010;
    step();
    checks++;
    if (q !== 4'hC) begin
      fails++; $display("FAIL jk_first got %h exp C", q);
    end
    step();
    checks++;
    if (q !== 4'h4) begin
      fails++; $display("FAIL jk_second got %h exp 4", q);
    end
  endtask

  task automatic test_sr_mode();
    en = 1; mode = 2'b00; a = 4'h5; b = 4'h0;
    step();
    mode = 2'b11; a = 4'b0011; b = 4'b0001;
    step();
    checks++;
    if (q !== 4'h7 || err !== 1'b1) begin
      fails++;
      $display("FAIL sr_illegal q=%h err=%b exp 7 1", q, err);
    end
    clr_err = 1;
    step();
    checks++;
    if (q !== 4'h7 || err !== 1'b1) begin
      fails++;
      $display("FAIL sr_set_wins q=%h err=%b exp 7 1", q, err);
    end
    mode = 2'b00; a = 4'h7;
    step();
    checks++;
    if (err !== 1'b0 || q !== 4'h7) begin
      fails++;
      $display("FAIL sr_clear q=%h err=%b exp 7 0", q, err);
    end
    clr_err = 0;
    mode = 2'b11; a = 4'b1000; b = 4'b0110;
    step();
    checks++;
    if (q !== 4'h9 || err !== 1'b0) begin
      fails++;
      $display("FAIL sr_legal q=%h err=%b exp 9 0", q, err);
    end
  endtask

  task automatic test_reset_precedence();
    en = 1; mode = 2'b11; a = 4'hF; b = 4'hF;
    step();
    checks++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL prec_setup err=%b exp 1", err);
    end
    reset_sync = 1;
    #2;
    checks++;
    if (err !== 1'b1 || q !== 4'h9) begin
      fails++;
      $display("FAIL reset_between_edges q=%h err=%b exp 9 1",
               q, err);
    end
    step();
    checks++;
    if (err !== 1'b0 || q !== 4'h0 || q_prev !== 4'h0
        || cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_prec q=%h prev=%h err=%b cnt=%0d exp 0",
               q, q_prev, err, cnt);
    end
    reset_sync = 0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    en = 1; mode = 2'b01; a = 4'h1; b = 4'h0; clr_err = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cnt2 !== exp_cnt[i]) begin
        fails++;
        $display("FAIL sat_cnt[%0d] got %0d exp %0d",
                 i, cnt2, exp_cnt[i]);
      end
    end
    checks++;
    if (cnt !== 8'd5 || q2 !== 4'h1) begin
      fails++;
      $display("FAIL sat_wide cnt=%0d q2=%h exp 5 1", cnt, q2);
    end
    reset_sync = 1;
    step();
    checks++;
    if (cnt2 !== 2'd0 || q2 !== 4'h0) begin
      fails++;
      $display("FAIL sat_reset cnt2=%0d q2=%h exp 0 0", cnt2, q2);
    end
    reset_sync = 0;
    step();
    checks++;
    if (cnt2 !== 2'd1 || q2 !== 4'h1) begin
      fails++;
      $display("FAIL sat_resume cnt2=%0d q2=%h exp 1 1", cnt2, q2);
    end
  endtask

  initial begin
    reset_sync = 1; en = 0; mode = 2'b00;
    a = 4'h0; b = 4'h0; clr_err = 0;
    test_reset();
    test_d_mode();
    test_t_mode();
    test_en_hold();
    test_jk_mode();
    test_sr_mode();
    test_reset_precedence();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
